// File: rtl/move_arbiter.sv
// Settled-board owner for the falling piece: checks proposals against the board,
// answers commit/decline/steal, merges landed pieces and clears full rows.
module move_arbiter #(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        movement_request,
  input  logic        movement_intent,
  input  logic [4:0]  P1blk_v,
  input  logic [4:0]  P1blk_h,
  input  logic [4:0]  P2blk_v,
  input  logic [4:0]  P2blk_h,
  input  logic [4:0]  P3blk_v,
  input  logic [4:0]  P3blk_h,
  input  logic [4:0]  P4blk_v,
  input  logic [4:0]  P4blk_h,
  input  logic [2:0]  volatile_blk_color,
  output logic        movement_commit,
  output logic        movement_declined,
  output logic        movement_steal,
  input  logic [4:0]  rd_row,
  input  logic [4:0]  rd_col,
  output logic [2:0]  rd_color,
  output logic [15:0] lines_cleared,
  output logic        game_over
);

  // state   | meaning
  // IDLE    | waiting for a proposal
  // CHECK   | testing proposed block k (1..4) against the board
  // DECIDE  | collision result complete, answer issued
  // WAITLOW | commit given, waiting for request to drop
  // DECLINE | move rejected, declined held until request drops
  // STEAL   | piece landed, waiting for request to drop
  // MERGE   | writing the committed cells into the board
  // SCAN    | testing row r for fullness, bottom up
  // SHIFT   | moving rows above s down by one
  // RELEASE | dropping steal, back to IDLE
  // OVER    | game over, terminal until reset
  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] CHECK   = 4'd1;
  localparam logic [3:0] DECIDE  = 4'd2;
  localparam logic [3:0] WAITLOW = 4'd3;
  localparam logic [3:0] DECLINE = 4'd4;
  localparam logic [3:0] STEAL   = 4'd5;
  localparam logic [3:0] MERGE   = 4'd6;
  localparam logic [3:0] SCAN    = 4'd7;
  localparam logic [3:0] SHIFT   = 4'd8;
  localparam logic [3:0] RELEASE = 4'd9;
  localparam logic [3:0] OVER    = 4'd10;

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [4:0] ROWS_L   = 5'(ROWS);
  localparam logic [4:0] COLS_L   = 5'(COLS);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  logic [3:0]  r_state;
  logic [1:0]  r_k;
  logic        r_coll;
  logic        r_intent;
  logic [2:0]  r_color;
  logic [4:0]  r_lh [4];
  logic [4:0]  r_lv [4];
  logic [4:0]  r_ch [4];
  logic [4:0]  r_cv [4];
  logic        r_cvalid;
  logic [4:0]  r_r;
  logic [4:0]  r_s;
  logic [2:0]  r_board [ROWS][COLS];
  logic [15:0] r_lines;
  logic        r_over;
  logic        r_commit;
  logic        r_decl;
  logic        r_steal;
  logic [2:0]  r_rd;

  logic [4:0] w_ph, w_pv, w_mh, w_mv, w_sm1;
  logic [2:0] w_cell, w_mcolor, w_rd_cell;
  logic       w_hit, w_min, w_any_top, w_full, w_rd_in;

  assign w_ph   = r_lh[r_k];
  assign w_pv   = r_lv[r_k];
  assign w_cell = r_board[w_ph[RW-1:0]][w_pv[CW-1:0]];
  // out-of-range coordinates (including 0-1 wrap to 31) count as collisions
  assign w_hit  = (w_ph >= ROWS_L) || (w_pv >= COLS_L) || (w_cell != 3'd0);

  assign w_mh      = r_ch[r_k];
  assign w_mv      = r_cv[r_k];
  assign w_min     = (w_mh < ROWS_L) && (w_mv < COLS_L);
  assign w_mcolor  = (r_color == 3'd0) ? 3'b111 : r_color;
  assign w_any_top = (r_ch[0] == 5'd0) || (r_ch[1] == 5'd0) ||
                     (r_ch[2] == 5'd0) || (r_ch[3] == 5'd0);
  assign w_sm1     = r_s - 5'd1;

  assign w_rd_in   = (rd_row < ROWS_L) && (rd_col < COLS_L);
  assign w_rd_cell = r_board[rd_row[RW-1:0]][rd_col[CW-1:0]];

  always_comb begin
    w_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (r_board[r_r[RW-1:0]][c] == 3'd0) w_full = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int h = 0; h < ROWS; h++) begin
        for (int c = 0; c < COLS; c++) begin
          r_board[h][c] <= 3'd0;
        end
      end
    end else begin
      if (r_state == MERGE && w_min) r_board[w_mh[RW-1:0]][w_mv[CW-1:0]] <= w_mcolor;
      if (r_state == SHIFT) begin
        for (int c = 0; c < COLS; c++) begin
          if (r_s == 5'd0) r_board[0][c] <= 3'd0;
          else             r_board[r_s[RW-1:0]][c] <= r_board[w_sm1[RW-1:0]][c];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd <= 3'd0;
    else       r_rd <= w_rd_in ? w_rd_cell : 3'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_k      <= 2'd0;
      r_coll   <= 1'b0;
      r_intent <= 1'b0;
      r_color  <= 3'd0;
      r_cvalid <= 1'b0;
      r_r      <= 5'd0;
      r_s      <= 5'd0;
      r_lines  <= 16'd0;
      r_over   <= 1'b0;
      r_commit <= 1'b0;
      r_decl   <= 1'b0;
      r_steal  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_lh[i] <= 5'd0;
        r_lv[i] <= 5'd0;
        r_ch[i] <= 5'd0;
        r_cv[i] <= 5'd0;
      end
    end else begin
      r_commit <= 1'b0;
      case (r_state)
        IDLE: begin
          if (movement_request && !r_over) begin
            r_lh[0]  <= P1blk_h;
            r_lv[0]  <= P1blk_v;
            r_lh[1]  <= P2blk_h;
            r_lv[1]  <= P2blk_v;
            r_lh[2]  <= P3blk_h;
            r_lv[2]  <= P3blk_v;
            r_lh[3]  <= P4blk_h;
            r_lv[3]  <= P4blk_v;
            r_intent <= movement_intent;
            r_color  <= volatile_blk_color;
            r_k      <= 2'd0;
            r_coll   <= 1'b0;
            r_state  <= CHECK;
          end
        end
        CHECK: begin
          r_coll <= r_coll | w_hit;
          r_k    <= r_k + 2'd1;
          if (r_k == 2'd3) r_state <= DECIDE;
        end
        DECIDE: begin
          if (!r_coll) begin
            r_commit <= 1'b1;
            r_ch     <= r_lh;
            r_cv     <= r_lv;
            r_cvalid <= 1'b1;
            r_state  <= WAITLOW;
          end else if (r_intent) begin
            r_decl  <= 1'b1;
            r_state <= DECLINE;
          end else begin
            r_steal <= 1'b1;
            r_state <= STEAL;
          end
        end
        WAITLOW: begin
          if (!movement_request) r_state <= IDLE;
        end
        DECLINE: begin
          if (!movement_request) begin
            r_decl  <= 1'b0;
            r_state <= IDLE;
          end
        end
        STEAL: begin
          if (!movement_request) begin
            // a piece that never managed a single fall means the spawn is blocked
            if (!r_cvalid) begin
              r_over  <= 1'b1;
              r_state <= OVER;
            end else begin
              r_k     <= 2'd0;
              r_state <= MERGE;
            end
          end
        end
        MERGE: begin
          r_k <= r_k + 2'd1;
          if (r_k == 2'd3) begin
            if (w_any_top) begin
              r_over  <= 1'b1;
              r_state <= OVER;
            end else begin
              r_r     <= LAST_ROW;
              r_state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (w_full) begin
            if (r_lines != 16'hFFFF) r_lines <= r_lines + 16'd1;
            r_s     <= r_r;
            r_state <= SHIFT;
          end else if (r_r == 5'd0) begin
            r_state <= RELEASE;
          end else begin
            r_r <= r_r - 5'd1;
          end
        end
        SHIFT: begin
          // same r is rescanned so a row dropped into place is re-tested
          if (r_s == 5'd0) r_state <= SCAN;
          else             r_s <= w_sm1;
        end
        RELEASE: begin
          r_steal  <= 1'b0;
          r_cvalid <= 1'b0;
          r_state  <= IDLE;
        end
        OVER: r_state <= OVER;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign movement_commit   = r_commit;
  assign movement_declined = r_decl;
  assign movement_steal    = r_steal;
  assign rd_color          = r_rd;
  assign lines_cleared     = r_lines;
  assign game_over         = r_over;

endmodule
